// File: rtl/spi_ram_ctrl_if.sv
// spi_ram_ctrl_if: rx/tx word bundle between the SPI slave and the RAM controller.
// master = SPI slave side, slave = RAM controller side.
interface spi_ram_ctrl_if #(
    parameter int ADDR_SIZE = 8
);
    logic [ADDR_SIZE+1:0] rx_data;
    logic                 rx_valid;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;

    modport master (
        output rx_data,
        output rx_valid,
        input  tx_data,
        input  tx_valid
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output tx_data,
        output tx_valid
    );
endinterface

// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: command decoder + single-port RAM behind the SPI slave.
// Optional macro SPI_RAM_AUTO_INC_EN: post-increment wr_addr on write, rd_addr on fetch.
module spi_ram_ctrl #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256,
    parameter int TX_HOLD   = 10
) (
    input logic           clk,
    input logic           rst,
    spi_ram_ctrl_if.slave bus
);
    localparam int HW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t               state;
    logic [ADDR_SIZE-1:0] mem [0:MEM_DEPTH-1];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] tx_data;
    logic                 tx_valid;
    logic [HW-1:0]        hold_cnt;

    logic [1:0]           cmd;
    logic [ADDR_SIZE-1:0] payload;
    logic                 do_wa;
    logic                 do_wr;
    logic                 do_ra;
    logic                 do_rd;

    // Reduce an incoming address into the RAM range.
    function automatic logic [ADDR_SIZE-1:0] wrap(input logic [ADDR_SIZE-1:0] a);
        logic [31:0] t;
        t = 32'(a) % 32'(MEM_DEPTH);
        return t[ADDR_SIZE-1:0];
    endfunction

`ifdef SPI_RAM_AUTO_INC_EN
    // Next address with wrap at the top of the RAM.
    function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
        return (a == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : a + 1'b1;
    endfunction
`endif

    assign cmd     = bus.rx_data[ADDR_SIZE+1:ADDR_SIZE];
    assign payload = bus.rx_data[ADDR_SIZE-1:0];
    assign do_wa   = bus.rx_valid && (cmd == 2'b00);
    assign do_wr   = bus.rx_valid && (cmd == 2'b01);
    assign do_ra   = bus.rx_valid && (cmd == 2'b10);
    assign do_rd   = bus.rx_valid && (cmd == 2'b11);

    assign bus.tx_data  = tx_data;
    assign bus.tx_valid = tx_valid;

    // RAM write port; contents deliberately not reset. Fetch reads old data on a same-edge write.
    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_addr] <= payload;
    end

    // Address registers and read FSM with registered tx outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            wr_addr  <= '0;
            rd_addr  <= '0;
            hold_cnt <= '0;
        end else begin
`ifdef SPI_RAM_AUTO_INC_EN
            if (do_wr)
                wr_addr <= inc(wr_addr);
            if (state == FETCH)
                rd_addr <= inc(rd_addr);
`endif
            // Explicit address loads override any increment on the same edge.
            if (do_wa)
                wr_addr <= wrap(payload);
            if (do_ra)
                rd_addr <= wrap(payload);

            unique case (state)
                IDLE: begin
                    if (do_rd)
                        state <= FETCH;
                end
                FETCH: begin
                    tx_data  <= mem[rd_addr];
                    tx_valid <= 1'b1;
                    hold_cnt <= HW'(TX_HOLD - 1);
                    state    <= do_rd ? FETCH : HOLD;
                end
                HOLD: begin
                    if (bus.rx_valid) begin
                        tx_valid <= 1'b0;
                        state    <= do_rd ? FETCH : IDLE;
                    end else if (hold_cnt == '0) begin
                        tx_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed tests for spi_ram_ctrl (ADDR_SIZE=8, MEM_DEPTH=256, TX_HOLD=10).
// Expectations follow SPI_RAM_AUTO_INC_EN when it is defined for the build.
module tb_spi_ram_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    spi_ram_ctrl_if #(.ADDR_SIZE(8)) bus ();

    spi_ram_ctrl #(
        .ADDR_SIZE(8),
        .MEM_DEPTH(256),
        .TX_HOLD  (10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one command for one sampling edge; returns 1ns after that edge.
    task automatic send(input logic [1:0] c, input logic [7:0] p);
        bus.rx_data  = {c, p};
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.tx_valid && n < 30) begin
            step();
            n++;
        end
        vectors++;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_idle: tx_valid %b want 0 after 30 cycles", bus.tx_valid);
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) step();
        vectors += 2;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tx_valid: got %b want 0", bus.tx_valid);
        end
        if (bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_tx_data: got %h want 00", bus.tx_data);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        int cnt;
        send(2'b00, 8'h12);
        send(2'b01, 8'hA5);
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        vectors++;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_rd_early: tx_valid %b want 0", bus.tx_valid);
        end
        step();
        vectors += 2;
        if (bus.tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_rd_latency: tx_valid %b want 1", bus.tx_valid);
        end
        if (bus.tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL wr_rd_data: got %h want a5", bus.tx_data);
        end
        cnt = 1;
        for (int i = 0; i < 30 && bus.tx_valid; i++) begin
            step();
            if (bus.tx_valid) begin
                cnt++;
                vectors++;
                if (bus.tx_data !== 8'hA5) begin
                    miscompares++;
                    $display("FAIL wr_rd_hold_data: got %h want a5", bus.tx_data);
                end
            end
        end
        vectors += 2;
        if (cnt != 10) begin
            miscompares++;
            $display("FAIL wr_rd_window: got %0d cycles want 10", cnt);
        end
        if (bus.tx_data !== 8'hA5) begin
            miscompares++;
            $display("FAIL wr_rd_after: got %h want a5", bus.tx_data);
        end
    endtask

    task automatic test_abort();
        send(2'b00, 8'h30);
        send(2'b01, 8'h5C);
        send(2'b10, 8'h30);
        send(2'b11, 8'h00);
        repeat (3) step();
        vectors++;
        if (bus.tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_pre: tx_valid %b want 1", bus.tx_valid);
        end
        send(2'b00, 8'h03);
        vectors += 2;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_valid: tx_valid %b want 0", bus.tx_valid);
        end
        if (bus.tx_data !== 8'h5C) begin
            miscompares++;
            $display("FAIL abort_data: got %h want 5c", bus.tx_data);
        end
        send(2'b01, 8'h77);
        send(2'b10, 8'h03);
        send(2'b11, 8'h00);
        step();
        vectors++;
        if (bus.tx_data !== 8'h77) begin
            miscompares++;
            $display("FAIL abort_wr_addr: got %h want 77", bus.tx_data);
        end
        wait_idle();
    endtask

    task automatic test_collision();
        send(2'b00, 8'h40);
        send(2'b01, 8'h11);
        send(2'b10, 8'h40);
        send(2'b00, 8'h40);
        send(2'b11, 8'h00);
        send(2'b01, 8'h22);
        vectors += 2;
        if (bus.tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL coll_valid: tx_valid %b want 1", bus.tx_valid);
        end
        if (bus.tx_data !== 8'h11) begin
            miscompares++;
            $display("FAIL coll_old: got %h want 11", bus.tx_data);
        end
        wait_idle();
        send(2'b10, 8'h40);
        send(2'b11, 8'h00);
        step();
        vectors++;
        if (bus.tx_data !== 8'h22) begin
            miscompares++;
            $display("FAIL coll_new: got %h want 22", bus.tx_data);
        end
        wait_idle();
    endtask

    task automatic test_wrap();
        logic [7:0] exp_ff;
        logic [7:0] exp_00;
`ifdef SPI_RAM_AUTO_INC_EN
        exp_ff = 8'h01;
        exp_00 = 8'h02;
`else
        exp_ff = 8'h02;
        exp_00 = 8'h9E;
`endif
        send(2'b00, 8'h00);
        send(2'b01, 8'h9E);
        send(2'b00, 8'hFF);
        send(2'b01, 8'h01);
        send(2'b01, 8'h02);
        send(2'b10, 8'hFF);
        send(2'b11, 8'h00);
        step();
        vectors++;
        if (bus.tx_data !== exp_ff) begin
            miscompares++;
            $display("FAIL wrap_ff: got %h want %h", bus.tx_data, exp_ff);
        end
        wait_idle();
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        step();
        vectors++;
        if (bus.tx_data !== exp_00) begin
            miscompares++;
            $display("FAIL wrap_00: got %h want %h", bus.tx_data, exp_00);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp2;
        int         cnt;
`ifdef SPI_RAM_AUTO_INC_EN
        exp2 = 8'hB2;
`else
        exp2 = 8'hA1;
`endif
        send(2'b00, 8'h50);
        send(2'b01, 8'hA1);
        send(2'b00, 8'h51);
        send(2'b01, 8'hB2);
        send(2'b10, 8'h50);
        send(2'b11, 8'h00);
        send(2'b11, 8'h00);
        vectors += 2;
        if (bus.tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_first_valid: tx_valid %b want 1", bus.tx_valid);
        end
        if (bus.tx_data !== 8'hA1) begin
            miscompares++;
            $display("FAIL b2b_first_data: got %h want a1", bus.tx_data);
        end
        step();
        vectors += 2;
        if (bus.tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second_valid: tx_valid %b want 1", bus.tx_valid);
        end
        if (bus.tx_data !== exp2) begin
            miscompares++;
            $display("FAIL b2b_second_data: got %h want %h", bus.tx_data, exp2);
        end
        cnt = 1;
        for (int i = 0; i < 30 && bus.tx_valid; i++) begin
            step();
            if (bus.tx_valid)
                cnt++;
        end
        vectors++;
        if (cnt != 10) begin
            miscompares++;
            $display("FAIL b2b_window: got %0d cycles want 10", cnt);
        end
    endtask

    task automatic test_rst_mid_read();
        logic seen;
        send(2'b10, 8'h12);
        send(2'b11, 8'h00);
        repeat (3) step();
        vectors++;
        if (bus.tx_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: tx_valid %b want 1", bus.tx_valid);
        end
        rst = 1'b1;
        #1;
        vectors += 2;
        if (bus.tx_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async_valid: tx_valid %b want 0", bus.tx_valid);
        end
        if (bus.tx_data !== 8'h00) begin
            miscompares++;
            $display("FAIL rst_async_data: got %h want 00", bus.tx_data);
        end
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            step();
            seen |= bus.tx_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_resp: tx_valid seen %b want 0", seen);
        end
        send(2'b11, 8'h00);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            step();
            seen |= bus.tx_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_fetch_drop: tx_valid seen %b want 0", seen);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_write_read();
        test_abort();
        test_collision();
        test_wrap();
        test_back_to_back();
        test_rst_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
